// File: rtl/bullet_flight_ctl_pkg.sv
// Shared types and screen constants for the bullet flight controller and the bullet renderer.
package bullet_flight_ctl_pkg;

    localparam int SCREEN_W        = 800;
    localparam int SCREEN_H        = 600;
    localparam int STEP            = 4;
    localparam int TANK_W          = 32;
    localparam int TANK_H          = 32;
    localparam int HIT_FRAMES      = 8;
    localparam int COOLDOWN_FRAMES = 30;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLY      = 2'd1,
        HIT      = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bullet_flight_ctl_if.sv
// Control/status bundle between a tank's game logic and its bullet flight controller.
interface bullet_flight_ctl_if;
    logic       vsync;
    logic       fire;
    logic [9:0] muzzle_x;
    logic [9:0] muzzle_y;
    logic [1:0] dir;
    logic [9:0] target_x;
    logic [9:0] target_y;
    logic [9:0] xpos_bullet;
    logic [9:0] ypos_bullet;
    logic       busy;
    logic       hit;
    logic       hit_active;

    modport master (
        output vsync, fire, muzzle_x, muzzle_y, dir, target_x, target_y,
        input  xpos_bullet, ypos_bullet, busy, hit, hit_active
    );

    modport slave (
        input  vsync, fire, muzzle_x, muzzle_y, dir, target_x, target_y,
        output xpos_bullet, ypos_bullet, busy, hit, hit_active
    );
endinterface

// File: rtl/bullet_flight_ctl_frame_tick_gen.sv
// Rising-edge detector on vsync: one-cycle tick at the start of each frame.
module frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic tick
);
    logic vsync_q;

    always_ff @(posedge clk) begin
        if (rst) vsync_q <= 1'b0;
        else     vsync_q <= vsync;
    end

    assign tick = vsync & ~vsync_q;
endmodule

// File: rtl/bullet_flight_ctl.sv
// Single-bullet life cycle: fire, per-frame flight, hit/edge detection, impact hold, reload cooldown.
module bullet_flight_ctl
    import bullet_flight_ctl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    bullet_flight_ctl_if.slave bus
);
    localparam int CNT_W = $clog2(max_int(HIT_FRAMES, COOLDOWN_FRAMES) + 1);

    state_t           state_reg;
    dir_t             dir_reg;
    logic [9:0]       x_reg, y_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg, hit_reg, hit_active_reg;
    logic             tick;

    frame_tick_gen u_tick (
        .clk   (clk),
        .rst   (rst),
        .vsync (bus.vsync),
        .tick  (tick)
    );

    // 11-bit arithmetic keeps box and edge sums from wrapping near the 10-bit limit.
    logic [10:0] x11, y11, tx11, ty11;
    logic        in_box, at_edge;

    assign x11  = {1'b0, x_reg};
    assign y11  = {1'b0, y_reg};
    assign tx11 = {1'b0, bus.target_x};
    assign ty11 = {1'b0, bus.target_y};
    assign in_box = (x11 >= tx11) && (x11 < tx11 + 11'(TANK_W)) &&
                    (y11 >= ty11) && (y11 < ty11 + 11'(TANK_H));

    always_comb begin
        at_edge = 1'b0;
        case (dir_reg)
            DIR_UP:    at_edge = y11 < 11'(STEP);
            DIR_RIGHT: at_edge = x11 + 11'(STEP) >= 11'(SCREEN_W);
            DIR_DOWN:  at_edge = y11 + 11'(STEP) >= 11'(SCREEN_H);
            DIR_LEFT:  at_edge = x11 < 11'(STEP);
            default:   at_edge = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            dir_reg        <= DIR_UP;
            x_reg          <= '0;
            y_reg          <= '0;
            cnt_reg        <= '0;
            busy_reg       <= 1'b0;
            hit_reg        <= 1'b0;
            hit_active_reg <= 1'b0;
        end else begin
            hit_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    x_reg          <= '0;
                    y_reg          <= '0;
                    busy_reg       <= 1'b0;
                    hit_active_reg <= 1'b0;
                    cnt_reg        <= '0;
                    if (bus.fire) begin
                        state_reg <= FLY;
                        dir_reg   <= dir_t'(bus.dir);
                        busy_reg  <= 1'b1;
                        y_reg     <= bus.muzzle_y;
                        // (0,0) is the renderer's "no bullet" marker, so nudge a zero spawn.
                        if (bus.muzzle_x == '0 && bus.muzzle_y == '0) x_reg <= 10'd1;
                        else                                          x_reg <= bus.muzzle_x;
                    end
                end
                FLY: if (tick) begin
                    if (in_box) begin
                        state_reg      <= HIT;
                        hit_reg        <= 1'b1;
                        hit_active_reg <= 1'b1;
                        cnt_reg        <= '0;
                    end else if (at_edge) begin
                        state_reg <= COOLDOWN;
                        x_reg     <= '0;
                        y_reg     <= '0;
                        cnt_reg   <= '0;
                    end else begin
                        case (dir_reg)
                            DIR_UP:    y_reg <= y_reg - 10'(STEP);
                            DIR_RIGHT: x_reg <= x_reg + 10'(STEP);
                            DIR_DOWN:  y_reg <= y_reg + 10'(STEP);
                            default:   x_reg <= x_reg - 10'(STEP);
                        endcase
                    end
                end
                HIT: if (tick) begin
                    if (cnt_reg == CNT_W'(HIT_FRAMES - 1)) begin
                        state_reg      <= COOLDOWN;
                        x_reg          <= '0;
                        y_reg          <= '0;
                        hit_active_reg <= 1'b0;
                        cnt_reg        <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                COOLDOWN: if (tick) begin
                    if (cnt_reg == CNT_W'(COOLDOWN_FRAMES - 1)) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    x_reg          <= '0;
                    y_reg          <= '0;
                    busy_reg       <= 1'b0;
                    hit_active_reg <= 1'b0;
                    cnt_reg        <= '0;
                end
            endcase
        end
    end

    assign bus.xpos_bullet = x_reg;
    assign bus.ypos_bullet = y_reg;
    assign bus.busy        = busy_reg;
    assign bus.hit         = hit_reg;
    assign bus.hit_active  = hit_active_reg;
endmodule

// File: tb/tb_bullet_flight_ctl.sv
// Directed bench for bullet_flight_ctl: one frame = vsync high one cycle, low one cycle.
module tb_bullet_flight_ctl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    bullet_flight_ctl_if bus ();

    bullet_flight_ctl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        bus.vsync = 1'b1;
        step();
        bus.vsync = 1'b0;
        step();
    endtask

    // Packs {x, y, busy, hit, hit_active} into one compared word.
    task automatic check(input string tag, input logic [9:0] x, input logic [9:0] y,
                         input logic b, input logic h, input logic ha);
        logic [22:0] obs, exp;
        obs = {bus.xpos_bullet, bus.ypos_bullet, bus.busy, bus.hit, bus.hit_active};
        exp = {x, y, b, h, ha};
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed x=%0d y=%0d busy=%b hit=%b act=%b, expected x=%0d y=%0d busy=%b hit=%b act=%b",
                   tag, obs[22:13], obs[12:3], obs[2], obs[1], obs[0], x, y, b, h, ha);
        end
        $display("check %-16s x=%0d y=%0d busy=%b hit=%b act=%b", tag,
                 bus.xpos_bullet, bus.ypos_bullet, bus.busy, bus.hit, bus.hit_active);
    endtask

    task automatic set_shot(input logic [9:0] mx, input logic [9:0] my, input logic [1:0] d,
                            input logic [9:0] tx, input logic [9:0] ty);
        bus.muzzle_x = mx;
        bus.muzzle_y = my;
        bus.dir      = d;
        bus.target_x = tx;
        bus.target_y = ty;
    endtask

    task automatic fire_once();
        bus.fire = 1'b1;
        step();
        bus.fire = 1'b0;
    endtask

    initial begin
        bus.vsync = 1'b0;
        bus.fire  = 1'b0;
        set_shot(10'd0, 10'd0, 2'd0, 10'd500, 10'd500);

        // Reset, then idle frames
        step();
        step();
        check("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;
        repeat (3) frame();
        check("idle_frames", 0, 0, 0, 0, 0);

        // Right-flight miss to the screen edge
        set_shot(10'd100, 10'd200, 2'd1, 10'd0, 10'd500);
        fire_once();
        check("right_spawn", 100, 200, 1, 0, 0);
        repeat (3) frame();
        check("right_3ticks", 112, 200, 1, 0, 0);
        repeat (171) frame();
        check("right_x796", 796, 200, 1, 0, 0);
        frame();
        check("right_edge", 0, 0, 1, 0, 0);
        repeat (29) frame();
        check("cool_29", 0, 0, 1, 0, 0);
        frame();
        check("cool_done", 0, 0, 0, 0, 0);

        // Downward hit on a target at (290,116)
        set_shot(10'd300, 10'd100, 2'd2, 10'd290, 10'd116);
        fire_once();
        check("hit_spawn", 300, 100, 1, 0, 0);
        repeat (4) frame();
        check("hit_y116", 300, 116, 1, 0, 0);
        bus.vsync = 1'b1;
        step();
        check("hit_pulse", 300, 116, 1, 1, 1);
        bus.vsync = 1'b0;
        step();
        check("hit_pulse_end", 300, 116, 1, 0, 1);
        repeat (7) frame();
        check("hit_hold7", 300, 116, 1, 0, 1);
        frame();
        check("hit_release", 0, 0, 1, 0, 0);
        repeat (30) frame();
        check("hit_cool_done", 0, 0, 0, 0, 0);

        // Left edge: first tick goes straight to cooldown
        set_shot(10'd3, 10'd50, 2'd3, 10'd500, 10'd500);
        fire_once();
        check("left_spawn", 3, 50, 1, 0, 0);
        frame();
        check("left_edge", 0, 0, 1, 0, 0);
        fire_once();
        check("fire_in_cool", 0, 0, 1, 0, 0);

        // Fire held through cooldown end; zero muzzle spawns at (1,0)
        set_shot(10'd0, 10'd0, 2'd1, 10'd500, 10'd500);
        bus.fire = 1'b1;
        repeat (29) frame();
        check("held_cooldown", 0, 0, 1, 0, 0);
        frame();
        check("refire_zero", 1, 0, 1, 0, 0);
        bus.fire = 1'b0;

        // Fire during flight is ignored; latched dir persists
        set_shot(10'd500, 10'd500, 2'd3, 10'd500, 10'd500);
        fire_once();
        check("fire_in_fly", 1, 0, 1, 0, 0);
        frame();
        check("dir_kept", 5, 0, 1, 0, 0);

        // Reset mid-flight
        rst = 1'b1;
        step();
        check("rst_mid_fly", 0, 0, 0, 0, 0);
        rst = 1'b0;
        step();

        // Fire coincident with a tick: no move that frame
        set_shot(10'd100, 10'd300, 2'd0, 10'd500, 10'd500);
        bus.fire  = 1'b1;
        bus.vsync = 1'b1;
        step();
        bus.fire  = 1'b0;
        bus.vsync = 1'b0;
        check("fire_on_tick", 100, 300, 1, 0, 0);
        step();
        check("no_move_frame", 100, 300, 1, 0, 0);
        frame();
        check("up_move", 100, 296, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
